// File: rtl/llc_pkg.sv
// Shared geometry, coherence enums and line/step payload types for the LLC model.
package LLC_defs;

    localparam int unsigned NUM_SETS      = 16384;
    localparam int unsigned ASSOCIATIVITY = 16;
    localparam int unsigned ADDR_W        = 32;
    localparam int unsigned OFFSET_W      = 6;
    localparam int unsigned INDEX_W       = 14;
    localparam int unsigned TAG_W         = 12;
    localparam int unsigned WAY_W         = 4;
    localparam int unsigned LVL_W         = 2;
    localparam int unsigned PLRU_W        = ASSOCIATIVITY - 1;

    typedef enum logic [1:0] {I, S, E, M} mesi;
    typedef enum logic [2:0] {NONE, READ, WRITE, INVALIDATE, RWIM} busOperation;
    typedef enum logic [1:0] {NOHIT, HIT, HITM} snoopResults;
    // MSG_NONE avoids a literal clash with busOperation's NONE in this scope
    typedef enum logic [2:0] {MSG_NONE, GETLINE, SENDLINE, INVALIDATELINE, EVICTLINE} messages;

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        mesi              state;
    } cache;

    typedef struct packed {
        busOperation bus;
        snoopResults snp;
        messages     msg;
    } step_t;

    localparam step_t STEP_IDLE = '{bus: NONE, snp: NOHIT, msg: MSG_NONE};

    // Snoop result other caches return for our READ/RWIM, encoded in the trace address
    function automatic snoopResults other_snoop(input logic [1:0] lsb);
        if (lsb[1])       return NOHIT;
        else if (lsb[0])  return HITM;
        else              return HIT;
    endfunction

endpackage

// File: rtl/llc_plru.sv
// Tree pseudo-LRU for one set: victim walk and access update (bit 0 = left, 1 = right).
module llc_plru
    import LLC_defs::*;
(
    input  logic [PLRU_W-1:0] i_bits,
    input  logic [WAY_W-1:0]  i_way,
    output logic [WAY_W-1:0]  o_victim_c,
    output logic [PLRU_W-1:0] o_bits_c
);

    always_comb begin : victim_walk
        int unsigned node;
        node       = 0;
        o_victim_c = '0;
        for (int lvl = 0; lvl < int'(WAY_W); lvl++) begin
            o_victim_c[LVL_W'(int'(WAY_W) - 1 - lvl)] = i_bits[WAY_W'(node)];
            node = 2 * node + 1 + 32'(i_bits[WAY_W'(node)]);
        end
    end

    // Path bits are pointed away from the accessed way
    always_comb begin : access_update
        int unsigned node;
        node     = 0;
        o_bits_c = i_bits;
        for (int lvl = 0; lvl < int'(WAY_W); lvl++) begin
            o_bits_c[WAY_W'(node)] = ~i_way[LVL_W'(int'(WAY_W) - 1 - lvl)];
            node = 2 * node + 1 + 32'(i_way[LVL_W'(int'(WAY_W) - 1 - lvl)]);
        end
    end

endmodule

// File: rtl/llc.sv
// Last-level cache: MESI coherence with tree PLRU, one trace op per idle cycle,
// multi-step bus/message sequences replayed through the hold counter.
module llc
    import LLC_defs::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  int          op,
    output int          cacheRds,
    output int          cacheWrs,
    output int          cacheHits,
    output int          cacheMisses,
    output busOperation busOp,
    output snoopResults snoopResult,
    output messages     message,
    output cache        LLC_cache [NUM_SETS][ASSOCIATIVITY],
    output int          hold
);

    logic [PLRU_W-1:0]  r_plru [NUM_SETS];
    step_t              r_step1, r_step2;

    logic [INDEX_W-1:0] w_index;
    logic [TAG_W-1:0]   w_tag;
    cache               w_set [ASSOCIATIVITY];
    logic               w_hit, w_inv_found, w_idle;
    logic [WAY_W-1:0]   w_hit_way, w_inv_way, w_victim, w_fill_way, w_acc_way;
    logic [PLRU_W-1:0]  w_plru_next;
    step_t              w_step0, w_step1, w_step2, w_fill_step;
    logic [1:0]         w_nsteps;
    cache               w_line;
    snoopResults        w_snp;
    logic               w_line_we, w_plru_we, w_clear;
    logic               w_rd_inc, w_wr_inc, w_hit_inc, w_miss_inc;

    assign w_index    = addr[OFFSET_W +: INDEX_W];
    assign w_tag      = addr[ADDR_W-1 -: TAG_W];
    assign w_idle     = (hold == 0);
    assign w_fill_way = w_inv_found ? w_inv_way : w_victim;
    assign w_acc_way  = w_hit ? w_hit_way : w_fill_way;

    always_comb begin
        for (int w = 0; w < int'(ASSOCIATIVITY); w++) w_set[w] = LLC_cache[w_index][w];
    end

    // Tag match and lowest invalid way (descending scan so the lowest wins)
    always_comb begin
        w_hit       = 1'b0;
        w_hit_way   = '0;
        w_inv_found = 1'b0;
        w_inv_way   = '0;
        for (int w = int'(ASSOCIATIVITY) - 1; w >= 0; w--) begin
            if (w_set[w].state == I) begin
                w_inv_found = 1'b1;
                w_inv_way   = WAY_W'(w);
            end else if (w_set[w].tag == w_tag) begin
                w_hit     = 1'b1;
                w_hit_way = WAY_W'(w);
            end
        end
    end

    llc_plru u_plru (
        .i_bits     (r_plru[w_index]),
        .i_way      (w_acc_way),
        .o_victim_c (w_victim),
        .o_bits_c   (w_plru_next)
    );

    always_comb begin
        w_step0     = STEP_IDLE;
        w_step1     = STEP_IDLE;
        w_step2     = STEP_IDLE;
        w_fill_step = STEP_IDLE;
        w_nsteps    = 2'd1;
        w_line      = w_set[w_acc_way];
        w_line_we   = 1'b0;
        w_plru_we   = 1'b0;
        w_clear     = 1'b0;
        w_rd_inc    = 1'b0;
        w_wr_inc    = 1'b0;
        w_hit_inc   = 1'b0;
        w_miss_inc  = 1'b0;
        w_snp       = NOHIT;
        if (w_hit) w_snp = (w_set[w_hit_way].state == M) ? HITM : HIT;

        case (op)
            0, 1, 2: begin
                w_rd_inc  = (op != 1);
                w_wr_inc  = (op == 1);
                w_line_we = 1'b1;
                w_plru_we = 1'b1;
                if (w_hit) begin
                    w_hit_inc = 1'b1;
                    if (op == 1) begin
                        if (w_set[w_hit_way].state == S) w_step0.bus = INVALIDATE;
                        w_line.state = M;
                    end else begin
                        w_step0.msg = SENDLINE;
                    end
                end else begin
                    w_miss_inc      = 1'b1;
                    w_line.valid    = 1'b1;
                    w_line.tag      = w_tag;
                    w_fill_step.msg = SENDLINE;
                    if (op == 1) begin
                        w_line.state    = M;
                        w_fill_step.bus = RWIM;
                    end else begin
                        w_line.state    = (other_snoop(addr[1:0]) == NOHIT) ? E : S;
                        w_fill_step.bus = READ;
                    end
                    // Dirty victim is written back before its eviction notice
                    if (w_inv_found) begin
                        w_step0 = w_fill_step;
                    end else if (w_set[w_fill_way].state == M) begin
                        w_step0  = '{bus: WRITE, snp: NOHIT, msg: GETLINE};
                        w_step1  = '{bus: NONE, snp: NOHIT, msg: EVICTLINE};
                        w_step2  = w_fill_step;
                        w_nsteps = 2'd3;
                    end else begin
                        w_step0.msg = EVICTLINE;
                        w_step1     = w_fill_step;
                        w_nsteps    = 2'd2;
                    end
                end
            end
            3: begin
                w_step0.snp = w_snp;
                if (w_hit && w_set[w_hit_way].state == M) begin
                    w_step0.bus  = WRITE;
                    w_step0.msg  = GETLINE;
                    w_line.state = S;
                    w_line_we    = 1'b1;
                end else if (w_hit && w_set[w_hit_way].state == E) begin
                    w_line.state = S;
                    w_line_we    = 1'b1;
                end
            end
            4: w_step0.snp = w_snp;
            5: begin
                w_step0.snp = w_snp;
                if (w_hit) begin
                    w_line.valid = 1'b0;
                    w_line.state = I;
                    w_line_we    = 1'b1;
                    if (w_set[w_hit_way].state == M) begin
                        w_step0.bus = WRITE;
                        w_step0.msg = GETLINE;
                        w_step1.msg = INVALIDATELINE;
                        w_nsteps    = 2'd2;
                    end else begin
                        w_step0.msg = INVALIDATELINE;
                    end
                end
            end
            6: begin
                w_step0.snp = w_snp;
                if (w_hit && w_set[w_hit_way].state == S) begin
                    w_step0.msg  = INVALIDATELINE;
                    w_line.valid = 1'b0;
                    w_line.state = I;
                    w_line_we    = 1'b1;
                end
            end
            8: w_clear = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busOp       <= NONE;
            snoopResult <= NOHIT;
            message     <= MSG_NONE;
            hold        <= 0;
            r_step1     <= STEP_IDLE;
            r_step2     <= STEP_IDLE;
            cacheRds    <= 0;
            cacheWrs    <= 0;
            cacheHits   <= 0;
            cacheMisses <= 0;
        end else if (!w_idle) begin
            busOp       <= r_step1.bus;
            snoopResult <= r_step1.snp;
            message     <= r_step1.msg;
            r_step1     <= r_step2;
            r_step2     <= STEP_IDLE;
            hold        <= hold - 1;
        end else begin
            busOp       <= w_step0.bus;
            snoopResult <= w_step0.snp;
            message     <= w_step0.msg;
            r_step1     <= w_step1;
            r_step2     <= w_step2;
            hold        <= int'(w_nsteps) - 1;
            if (w_clear) begin
                cacheRds    <= 0;
                cacheWrs    <= 0;
                cacheHits   <= 0;
                cacheMisses <= 0;
            end else begin
                cacheRds    <= cacheRds + int'(w_rd_inc);
                cacheWrs    <= cacheWrs + int'(w_wr_inc);
                cacheHits   <= cacheHits + int'(w_hit_inc);
                cacheMisses <= cacheMisses + int'(w_miss_inc);
            end
        end

        // Tag array and PLRU: wiped on reset or clear, else one set updated per accepted op
        if (rst || (w_idle && w_clear)) begin
            for (int unsigned si = 0; si < NUM_SETS; si++) begin
                r_plru[INDEX_W'(si)] <= '0;
                for (int unsigned wi = 0; wi < ASSOCIATIVITY; wi++)
                    LLC_cache[INDEX_W'(si)][WAY_W'(wi)] <= '0;
            end
        end else if (w_idle) begin
            if (w_line_we) LLC_cache[w_index][w_acc_way] <= w_line;
            if (w_plru_we) r_plru[w_index] <= w_plru_next;
        end
    end

endmodule

// File: tb/tb_llc.sv
// Randomized self-checking bench for llc against a set/way/tree reference model.
module tb_llc;
    import LLC_defs::*;

    localparam int B_NONE = 0, B_READ = 1, B_WRITE = 2, B_INV = 3, B_RWIM = 4;
    localparam int R_NOHIT = 0, R_HIT = 1, R_HITM = 2;
    localparam int G_NONE = 0, G_GET = 1, G_SEND = 2, G_INVL = 3, G_EVICT = 4;
    localparam int ST_I = 0, ST_S = 1, ST_E = 2, ST_M = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] addr = '0;
    int          op = 7;
    int          cacheRds, cacheWrs, cacheHits, cacheMisses, hold;
    busOperation busOp;
    snoopResults snoopResult;
    messages     message;
    cache        llc_cache [NUM_SETS][ASSOCIATIVITY];

    llc dut (
        .clk(clk), .rst(rst), .addr(addr), .op(op),
        .cacheRds(cacheRds), .cacheWrs(cacheWrs), .cacheHits(cacheHits), .cacheMisses(cacheMisses),
        .busOp(busOp), .snoopResult(snoopResult), .message(message),
        .LLC_cache(llc_cache), .hold(hold)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference model: sparse per-line state/tag, per-set tree bits, counters
    int m_st [int];
    int m_tag [int];
    int m_tree [int];
    int m_rds, m_wrs, m_hits, m_miss;
    int e_bus [$], e_snp [$], e_msg [$];

    function automatic int st(input int s, input int w);
        return m_st.exists(s * 16 + w) ? m_st[s * 16 + w] : ST_I;
    endfunction
    function automatic int tg_of(input int s, input int w);
        return m_tag.exists(s * 16 + w) ? m_tag[s * 16 + w] : 0;
    endfunction
    function automatic int exp_line(input int s, input int w);
        return ((st(s, w) != ST_I ? 1 : 0) << 14) | (tg_of(s, w) << 2) | st(s, w);
    endfunction

    function automatic void model_clear();
        m_st.delete(); m_tag.delete(); m_tree.delete();
        m_rds = 0; m_wrs = 0; m_hits = 0; m_miss = 0;
    endfunction

    function automatic void push(input int b, input int r, input int g);
        e_bus.push_back(b); e_snp.push_back(r); e_msg.push_back(g);
    endfunction

    function automatic int plru_victim(input int s);
        int t = m_tree.exists(s) ? m_tree[s] : 0;
        int n = 0, v = 0, b;
        for (int l = 0; l < 4; l++) begin
            b = (t >> n) & 1;
            v = v * 2 + b;
            n = 2 * n + 1 + b;
        end
        return v;
    endfunction

    // Node at level l on the path to way w is (2^l - 1) + (w >> (4-l))
    function automatic void touch(input int s, input int w);
        int t = m_tree.exists(s) ? m_tree[s] : 0;
        int n, b;
        for (int l = 0; l < 4; l++) begin
            n = (1 << l) - 1 + (w >> (4 - l));
            b = (w >> (3 - l)) & 1;
            if (b == 1) t = t & ~(1 << n);
            else        t = t | (1 << n);
        end
        m_tree[s] = t;
    endfunction

    function automatic void model_fill(input int s, input int tg, input int nst, input int bus);
        int v = -1;
        for (int w = 15; w >= 0; w--) if (st(s, w) == ST_I) v = w;
        if (v < 0) begin
            v = plru_victim(s);
            if (st(s, v) == ST_M) begin
                push(B_WRITE, R_NOHIT, G_GET);
                push(B_NONE, R_NOHIT, G_EVICT);
            end else begin
                push(B_NONE, R_NOHIT, G_EVICT);
            end
        end
        push(bus, R_NOHIT, G_SEND);
        m_st[s * 16 + v] = nst;
        m_tag[s * 16 + v] = tg;
        touch(s, v);
    endfunction

    function automatic void model_op(input int o, input logic [31:0] a);
        int s = int'(a[19:6]);
        int tg = int'(a[31:20]);
        int hw = -1, cur, res;
        e_bus.delete(); e_snp.delete(); e_msg.delete();
        for (int w = 0; w < 16; w++) if (st(s, w) != ST_I && tg_of(s, w) == tg) hw = w;
        cur = (hw >= 0) ? st(s, hw) : ST_I;
        res = (hw < 0) ? R_NOHIT : (cur == ST_M ? R_HITM : R_HIT);
        case (o)
            0, 2: begin
                m_rds++;
                if (hw >= 0) begin
                    m_hits++; push(B_NONE, R_NOHIT, G_SEND); touch(s, hw);
                end else begin
                    m_miss++;
                    model_fill(s, tg, a[1] ? ST_E : ST_S, B_READ);
                end
            end
            1: begin
                m_wrs++;
                if (hw >= 0) begin
                    m_hits++;
                    push(cur == ST_S ? B_INV : B_NONE, R_NOHIT, G_NONE);
                    m_st[s * 16 + hw] = ST_M; touch(s, hw);
                end else begin
                    m_miss++;
                    model_fill(s, tg, ST_M, B_RWIM);
                end
            end
            3: begin
                if (cur == ST_M) push(B_WRITE, R_HITM, G_GET);
                else             push(B_NONE, res, G_NONE);
                if (cur == ST_M || cur == ST_E) m_st[s * 16 + hw] = ST_S;
            end
            4: push(B_NONE, res, G_NONE);
            5: begin
                if (cur == ST_M) begin
                    push(B_WRITE, R_HITM, G_GET); push(B_NONE, R_NOHIT, G_INVL);
                end else if (hw >= 0) push(B_NONE, R_HIT, G_INVL);
                else                  push(B_NONE, R_NOHIT, G_NONE);
                if (hw >= 0) m_st[s * 16 + hw] = ST_I;
            end
            6: begin
                if (cur == ST_S) begin
                    push(B_NONE, R_HIT, G_INVL); m_st[s * 16 + hw] = ST_I;
                end else push(B_NONE, res, G_NONE);
            end
            8: begin model_clear(); push(B_NONE, R_NOHIT, G_NONE); end
            default: push(B_NONE, R_NOHIT, G_NONE);
        endcase
    endfunction

    task automatic check_state(input int s);
        check("rds", cacheRds, m_rds);
        check("wrs", cacheWrs, m_wrs);
        check("hits", cacheHits, m_hits);
        check("misses", cacheMisses, m_miss);
        for (int w = 0; w < 16; w++)
            check($sformatf("line[%0d][%0d]", s, w), int'(llc_cache[14'(s)][4'(w)]), exp_line(s, w));
    endtask

    // Drive one op; during its trailing steps feed junk that must be ignored
    task automatic do_op(input int o, input logic [31:0] a);
        int n;
        model_op(o, a);
        n = e_bus.size();
        op = o; addr = a;
        @(posedge clk); #1;
        for (int k = 0; k < n; k++) begin
            check($sformatf("op%0d step%0d bus", o, k), int'(busOp), e_bus[k]);
            check($sformatf("op%0d step%0d snoop", o, k), int'(snoopResult), e_snp[k]);
            check($sformatf("op%0d step%0d msg", o, k), int'(message), e_msg[k]);
            check($sformatf("op%0d step%0d hold", o, k), hold, n - 1 - k);
            if (k < n - 1) begin
                op = int'($urandom_range(0, 9)); addr = $urandom;
                @(posedge clk); #1;
            end
        end
        check_state(int'(a[19:6]));
    endtask

    int ops [12] = '{0, 0, 1, 1, 2, 3, 4, 5, 6, 7, 9, 10};

    initial begin
        int o;
        logic [31:0] a;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset bus", int'(busOp), B_NONE);
        check("reset snoop", int'(snoopResult), R_NOHIT);
        check("reset msg", int'(message), G_NONE);
        check("reset hold", hold, 0);
        check_state(0);
        check("reset last line", int'(llc_cache[14'(NUM_SETS - 1)][4'(ASSOCIATIVITY - 1)]), 0);

        do_op(0, 32'h0000_0002);
        check("first fill E", int'(llc_cache[0][0]), (1 << 14) | ST_E);
        do_op(1, 32'h0000_0002);
        do_op(3, 32'h0000_0002);
        do_op(1, 32'h0000_0002);
        do_op(5, 32'h0000_0002);
        for (int t = 0; t < 16; t++) do_op(0, (32'(t) << 20) | 32'h2);
        do_op(0, (32'h10 << 20) | 32'h2);
        check("evict refill way0", int'(llc_cache[0][0]), (1 << 14) | (16'h10 << 2) | ST_E);
        do_op(1, (32'h3 << 20) | 32'h1);
        for (int t = 4; t < 7; t++) do_op(1, (32'(t) << 20));
        do_op(0, (32'h11 << 20));
        do_op(8, 32'h0);
        do_op(9, 32'h0000_0002);

        for (int i = 0; i < 1500; i++) begin
            o = ops[$urandom_range(0, 11)];
            if ($urandom_range(0, 79) == 0) o = 8;
            a = {12'($urandom_range(0, 19)), 14'($urandom_range(0, 3)),
                 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
            do_op(o, a);
        end

        // Reset in the middle of a two-step snoop sequence
        a = (32'h7 << 20) | (32'd5 << 6);
        do_op(1, a);
        op = 5; addr = a;
        @(posedge clk); #1;
        check("pre-reset hold", hold, 1);
        check("pre-reset bus", int'(busOp), B_WRITE);
        rst = 1'b1; op = 7;
        @(posedge clk); #1;
        rst = 1'b0;
        model_clear();
        check("mid reset hold", hold, 0);
        check("mid reset bus", int'(busOp), B_NONE);
        check("mid reset msg", int'(message), G_NONE);
        check_state(5);
        do_op(0, a);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/llc.md
# llc

Last-level cache (LLC) behavioural model for the trace-driven multiprocessor cache simulator. Each cycle it accepts one trace operation (L1 request, snooped bus operation, clear, or print) and applies MESI coherence with pseudo-LRU replacement. It reports, one step per cycle, the bus operation it drives, the snoop result it returns, and the message it sends to L1. It also exposes the full tag array and the running statistics to the bench.

## Interface
- Parameters: none. Geometry comes from package `LLC_defs`: NUM_SETS=16384, ASSOCIATIVITY=16, 64 B lines, 32-bit address.
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- addr  in  32  trace address: tag [31:20], index [19:6], offset [5:0].
- op  in  int  trace operation code, 0–9.
- cacheRds, cacheWrs, cacheHits, cacheMisses  out  int  statistics counters.
- busOp  out  busOperation  bus operation of the current step.
- snoopResult  out  snoopResults  snoop result of the current step.
- message  out  messages  message to L1 for the current step.
- LLC_cache  out  cache [NUM_SETS][ASSOCIATIVITY]  line array; each entry holds {valid, tag[11:0], mesi}.
- hold  out  int  number of extra cycles (0–2) the current operation still occupies.

## Operation
- Ops 0 and 2 (read): count one read.
  - Hit: count a hit, message SENDLINE, state unchanged.
  - Miss: count a miss, busOp READ, message SENDLINE. New state is E if the other-cache snoop is NOHIT, otherwise S.
- Op 1 (write): count one write.
  - Hit in M: state stays M.
  - Hit in E: state becomes M.
  - Hit in S: busOp INVALIDATE, state becomes M.
  - Miss: busOp RWIM, message SENDLINE, line filled in M.
- Other-cache snoop result for our READ/RWIM comes from addr[1:0]: 00 gives HIT, 01 gives HITM, 1x gives NOHIT.
- Miss victim: the lowest invalid way; if the set is full, the PLRU way.
  - Victim M: step0 busOp WRITE + message GETLINE; step1 message EVICTLINE; step2 fill step.
  - Victim E/S: step0 message EVICTLINE; step1 fill step.
- Snoops, ops 3–6: snoopResult is HITM for M, HIT for E/S, NOHIT for I or a miss.
  - Op 3 (read): M line → busOp WRITE + message GETLINE, then S. E line → S. S unchanged.
  - Op 4 (write): no state change.
  - Op 5 (RWIM): M line → step0 GETLINE + WRITE, step1 INVALIDATELINE, then I. E/S line → INVALIDATELINE, then I.
  - Op 6 (invalidate): S line → INVALIDATELINE, then I.
- Op 8: invalidate all lines (tag 0, state I), clear PLRU bits and all counters.
- Op 9: no state change; outputs NONE/NOHIT.
- Op 7 and op > 9: no-op.
- PLRU: 15-bit tree per set; bit 0 selects left, 1 selects right.
  - Each L1 hit or fill (ops 0–2) sets the path bits to point away from the accessed way.
  - Snoops do not update the tree.
- Steps of an operation that drive nothing output NONE/NOHIT.

## Timing
- Reset: counters 0, busOp NONE, snoopResult NOHIT, message NONE, hold 0, all lines invalid, PLRU 0.
- When idle (hold==0), op/addr are sampled at every rising edge. Step0 outputs and all state, counter and PLRU updates are registered at that edge.
- hold is registered at the same edge as (steps−1). It decrements at each later edge while the remaining steps are output.
- While hold>0, op and addr are ignored.
- The environment presents exactly one operation per idle cycle. A repeated op value is executed again.
- Reset mid-sequence aborts the sequence and applies reset values.

## Structure
- Package `LLC_defs`: NUM_SETS, ASSOCIATIVITY, field widths.
  - Enums: mesi {I,S,E,M}; busOperation {NONE,READ,WRITE,INVALIDATE,RWIM}; snoopResults {NOHIT,HIT,HITM}; messages {NONE,GETLINE,SENDLINE,INVALIDATELINE,EVICTLINE}.
  - Struct `cache`.
- Sub-module `llc_plru`: combinational victim select plus update-vector logic for one set.

## Test plan
- Reset, op0 @0x00000002 → busOp READ, NOHIT, SENDLINE, hold 0, set 0 line E; Rds=1, Misses=1.
- op1 @0x00000002 → hit, E→M, busOp NONE; Wrs=1, Hits=1.
- op3 @0x00000002 → snoopResult HITM, busOp WRITE, message GETLINE, line S.
- op1 then op5 @0x00000002 → snoopResult HITM; cycle1 GETLINE+WRITE with hold 1; cycle2 INVALIDATELINE; line I.
- op0 to tags 0x000–0x00F in set 0 (addr = tag<<20 | 2), then tag 0x010 → hold 1: EVICTLINE for way 0, then READ+SENDLINE; way 0 holds tag 0x010 in E.
- op8 → all lines invalid, counters 0; a following op9 changes nothing.
